serial_adder_ctrl: RTL and testbench

//   Sequencer that runs one 1-bit FULL_ADDER bit-serially to do a WIDTH-bit add, LSB first.

---
 rtl/serial_adder_ctrl.sv | 115 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: drives one external 1-bit full adder bit-serially to add
// two WIDTH-bit operands LSB first, then presents {CARRY, SUM} with a DONE pulse.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             N_RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  input  logic             CIN_INIT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_CIN,
  input  logic             FA_SUM,
  input  logic             FA_COUT
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  // Only the upper WIDTH-1 collected bits are kept; the incoming adder bit
  // completes the word, so the bit that would fall off is never stored.
  logic [WIDTH-2:0] s_sh_q;
  logic [WIDTH-1:0] s_d;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  // Sum word as it will look after shifting in the current adder bit.
  always_comb begin
    s_d = {FA_SUM, s_sh_q};
  end

  // Sequencer: operand latch, bit-serial shifting, result capture and handshake.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            a_sh_q  <= IN_A;
            b_sh_q  <= IN_B;
            c_q     <= CIN_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          s_sh_q <= s_d[WIDTH-1:1];
          c_q    <= FA_COUT;
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= s_d;
            carry_q <= FA_COUT;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Adder inputs come straight from registers and are forced low outside RUN.
  always_comb begin
    FA_A   = (state_q == S_RUN) & a_sh_q[0];
    FA_B   = (state_q == S_RUN) & b_sh_q[0];
    FA_CIN = (state_q == S_RUN) & c_q;
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign SUM   = sum_q;
  assign CARRY = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=4) with a behavioural full adder
// attached to the FA_* ports.
module tb_serial_adder_ctrl;

  logic       CLK;
  logic       N_RESET;
  logic       START;
  logic [3:0] IN_A;
  logic [3:0] IN_B;
  logic       CIN_INIT;
  logic       BUSY;
  logic       DONE;
  logic [3:0] SUM;
  logic       CARRY;
  logic       FA_A;
  logic       FA_B;
  logic       FA_CIN;
  logic       FA_SUM;
  logic       FA_COUT;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(4)) dut (
    .CLK      (CLK),
    .N_RESET  (N_RESET),
    .START    (START),
    .IN_A     (IN_A),
    .IN_B     (IN_B),
    .CIN_INIT (CIN_INIT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .SUM      (SUM),
    .CARRY    (CARRY),
    .FA_A     (FA_A),
    .FA_B     (FA_B),
    .FA_CIN   (FA_CIN),
    .FA_SUM   (FA_SUM),
    .FA_COUT  (FA_COUT)
  );

  // Neighbouring full adder
  assign FA_SUM  = FA_A ^ FA_B ^ FA_CIN;
  assign FA_COUT = (FA_A & FA_B) | (FA_A & FA_CIN) | (FA_B & FA_CIN);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Start one add from IDLE and watch 20 cycles for DONE.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       output logic [3:0] s, output logic c, output int pulses);
    @(negedge CLK);
    IN_A = a; IN_B = b; CIN_INIT = cin; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    pulses = 0; s = '0; c = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (DONE) begin
        pulses++;
        s = SUM;
        c = CARRY;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    N_RESET = 1'b0; START = 1'b0; IN_A = '0; IN_B = '0; CIN_INIT = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE} !== 2'b00) begin
      errors++; $display("FAIL reset_busy_done: got %b expected 00", {BUSY, DONE});
    end
    checks++;
    if ({CARRY, SUM} !== 5'b0) begin
      errors++; $display("FAIL reset_result: got %b expected 00000", {CARRY, SUM});
    end
    checks++;
    if ({FA_A, FA_B, FA_CIN} !== 3'b000) begin
      errors++; $display("FAIL reset_fa: got %b expected 000", {FA_A, FA_B, FA_CIN});
    end
    N_RESET = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    logic [3:0] ea, eb, ec;
    ea = 4'b0011; eb = 4'b0101; ec = 4'b1110;  // bit i = value in RUN cycle i
    @(negedge CLK);
    IN_A = 4'b0011; IN_B = 4'b0101; CIN_INIT = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({BUSY, DONE} !== 2'b10) begin
        errors++; $display("FAIL basic_run_flags[%0d]: got %b expected 10", i, {BUSY, DONE});
      end
      checks++;
      if ({FA_A, FA_B, FA_CIN} !== {ea[i], eb[i], ec[i]}) begin
        errors++; $display("FAIL basic_fa_seq[%0d]: got %b expected %b", i,
                           {FA_A, FA_B, FA_CIN}, {ea[i], eb[i], ec[i]});
      end
      @(negedge CLK);
    end
    checks++;
    if ({BUSY, DONE} !== 2'b11) begin
      errors++; $display("FAIL basic_done_flags: got %b expected 11", {BUSY, DONE});
    end
    checks++;
    if ({CARRY, SUM} !== 5'b01000) begin
      errors++; $display("FAIL basic_result: got %b expected 01000", {CARRY, SUM});
    end
    checks++;
    if ({FA_A, FA_B, FA_CIN} !== 3'b000) begin
      errors++; $display("FAIL basic_fa_done: got %b expected 000", {FA_A, FA_B, FA_CIN});
    end
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, CARRY, SUM} !== 7'b0001000) begin
      errors++; $display("FAIL basic_idle_hold: got %b expected 0001000", {BUSY, DONE, CARRY, SUM});
    end
  endtask

  task automatic test_carry();
    logic [3:0] s;
    logic c;
    int p;
    do_op(4'b1111, 4'b0001, 1'b0, s, c, p);
    checks++;
    if ({p == 1, c, s} !== 6'b110000) begin
      errors++; $display("FAIL carry_wrap: got pulses=%0d %b expected pulses=1 10000", p, {c, s});
    end
    do_op(4'b1111, 4'b1111, 1'b1, s, c, p);
    checks++;
    if ({p == 1, c, s} !== 6'b111111) begin
      errors++; $display("FAIL carry_max: got pulses=%0d %b expected pulses=1 11111", p, {c, s});
    end
  endtask

  task automatic test_back_to_back();
    int p;
    logic [3:0] s;
    logic c;
    @(negedge CLK);
    IN_A = 4'b0001; IN_B = 4'b0001; CIN_INIT = 1'b0; START = 1'b1;
    @(negedge CLK);
    IN_A = 4'b1111; IN_B = 4'b1111;  // START stays high during RUN
    @(negedge CLK);
    @(negedge CLK);
    START = 1'b0;
    p = 0; s = '0; c = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (DONE) begin
        p++; s = SUM; c = CARRY;
      end
      @(negedge CLK);
    end
    checks++;
    if (p != 1) begin
      errors++; $display("FAIL ignore_start_pulses: got %0d expected 1", p);
    end
    checks++;
    if ({c, s} !== 5'b00010) begin
      errors++; $display("FAIL ignore_start_result: got %b expected 00010", {c, s});
    end
  endtask

  task automatic test_reset_abort();
    int p;
    logic [3:0] s;
    logic c;
    @(negedge CLK);
    IN_A = 4'b0110; IN_B = 4'b0001; CIN_INIT = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    N_RESET = 1'b0;
    #1;
    checks++;
    if ({BUSY, DONE, FA_A, FA_B, FA_CIN} !== 5'b00000) begin
      errors++; $display("FAIL abort_flags: got %b expected 00000", {BUSY, DONE, FA_A, FA_B, FA_CIN});
    end
    checks++;
    if ({CARRY, SUM} !== 5'b00000) begin
      errors++; $display("FAIL abort_result: got %b expected 00000", {CARRY, SUM});
    end
    @(negedge CLK);
    N_RESET = 1'b1;
    p = 0;
    for (int k = 0; k < 8; k++) begin
      if (DONE) p++;
      @(negedge CLK);
    end
    checks++;
    if (p != 0 || {CARRY, SUM} !== 5'b00000) begin
      errors++; $display("FAIL abort_no_done: got pulses=%0d %b expected pulses=0 00000", p, {CARRY, SUM});
    end
    do_op(4'b0100, 4'b0011, 1'b0, s, c, p);
    checks++;
    if ({p == 1, c, s} !== 6'b100111) begin
      errors++; $display("FAIL abort_recover: got pulses=%0d %b expected pulses=1 00111", p, {c, s});
    end
  endtask

  task automatic test_exhaustive();
    logic [8:0] idx;
    logic [4:0] exp_r;
    int k;
    bit timeout;
    timeout = 1'b0;
    @(negedge CLK);
    idx = '0;
    IN_A = idx[3:0]; IN_B = idx[7:4]; CIN_INIT = idx[8]; START = 1'b1;
    for (int n = 0; n < 512; n++) begin
      idx = 9'(n);
      exp_r = 5'(idx[3:0]) + 5'(idx[7:4]) + 5'(idx[8]);
      k = 0;
      do begin
        @(negedge CLK);
        k++;
      end while (!DONE && k < 20);
      checks++;
      if (!DONE) begin
        errors++; $display("FAIL exh_timeout[%0d]: got no DONE expected DONE within 20 cycles", n);
        timeout = 1'b1;
        break;
      end
      checks++;
      if ({CARRY, SUM} !== exp_r) begin
        errors++; $display("FAIL exh_result[%0d]: got %b expected %b", n, {CARRY, SUM}, exp_r);
      end
      checks++;
      if (k != 5) begin
        errors++; $display("FAIL exh_period[%0d]: got %0d expected 5 (6-cycle period)", n, k);
      end
      @(negedge CLK);
      checks++;
      if ({BUSY, DONE} !== 2'b00) begin
        errors++; $display("FAIL exh_done_width[%0d]: got %b expected 00", n, {BUSY, DONE});
      end
      idx = 9'(n + 1);
      IN_A = idx[3:0]; IN_B = idx[7:4]; CIN_INIT = idx[8];
      if (n == 511) START = 1'b0;
    end
    START = 1'b0;
    if (timeout) begin
      N_RESET = 1'b0;
      @(negedge CLK);
      N_RESET = 1'b1;
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
